// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter : two-requester round-robin arbiter onto a single memory bus
//   Optional WAIT timeout abort enabled by macro MEM_ARB_TIMEOUT_EN.
//   Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        CPU_rst,
  input  logic        r0_initiate_op,
  input  logic        r0_read_write,
  input  logic [15:0] r0_addr,
  input  logic [15:0] r0_wdata,
  output logic [15:0] r0_rdata,
  output logic        r0_op_complete,
  input  logic        r1_initiate_op,
  input  logic        r1_read_write,
  input  logic [15:0] r1_addr,
  input  logic [15:0] r1_wdata,
  output logic [15:0] r1_rdata,
  output logic        r1_op_complete,
  output logic [15:0] MAB,
  output logic        read_write,
  output logic        initiate_op,
  output logic [15:0] MDB_out,
  output logic        MDB_oe,
  input  logic [15:0] MDB_in,
  input  logic        op_complete,
  output logic [1:0]  grant,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  // last_q is both the round-robin history and the owner of the current transfer
  logic        last_q, last_d;
  logic [1:0]  grant_q, grant_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic [15:0] r0_rdata_q, r0_rdata_d;
  logic [15:0] r1_rdata_q, r1_rdata_d;
  logic        r0_done_q, r0_done_d;
  logic        r1_done_q, r1_done_d;
  logic        w_win;
  logic        w_timeout;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             berr_q;

  assign w_timeout = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge CPU_rst) begin
    if (CPU_rst) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else begin
      cnt_q  <= (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
      berr_q <= w_timeout && !op_complete;
    end
  end

  assign bus_error = berr_q;
`else
  assign w_timeout = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge CPU_rst) begin
    if (CPU_rst) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      grant_q    <= 2'b00;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      rw_q       <= 1'b0;
      r0_rdata_q <= 16'h0000;
      r1_rdata_q <= 16'h0000;
      r0_done_q  <= 1'b0;
      r1_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
      r0_done_q  <= r0_done_d;
      r1_done_q  <= r1_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    r0_done_d  = 1'b0;
    r1_done_d  = 1'b0;
    w_win      = last_q;
    case (state_q)
      S_IDLE: begin
        if (r0_initiate_op || r1_initiate_op) begin
          // Under contention the loser of the previous round wins this one
          w_win   = (r0_initiate_op && r1_initiate_op) ? ~last_q : r1_initiate_op;
          last_d  = w_win;
          grant_d = w_win ? 2'b10 : 2'b01;
          addr_d  = w_win ? r1_addr : r0_addr;
          rw_d    = w_win ? r1_read_write : r0_read_write;
          if (!rw_d) begin
            wdata_d = w_win ? r1_wdata : r0_wdata;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (op_complete || w_timeout) begin
          if (!op_complete) begin
            if (last_q) r1_rdata_d = 16'hFFFF;
            else        r0_rdata_d = 16'hFFFF;
          end else if (rw_q) begin
            if (last_q) r1_rdata_d = MDB_in;
            else        r0_rdata_d = MDB_in;
          end
          r0_done_d = ~last_q;
          r1_done_d = last_q;
          state_d   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!op_complete) begin
          grant_d = 2'b00;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign initiate_op    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign MDB_oe         = initiate_op && !rw_q;
  assign MAB            = addr_q;
  assign read_write     = rw_q;
  assign MDB_out        = wdata_q;
  assign grant          = grant_q;
  assign r0_rdata       = r0_rdata_q;
  assign r1_rdata       = r1_rdata_q;
  assign r0_op_complete = r0_done_q;
  assign r1_op_complete = r1_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_arbiter : directed vector bench for mem_bus_arbiter
//   Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_bus_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam int EXP_BE = 1;
`else
  localparam int TMO    = 64;
  localparam int EXP_BE = 0;
`endif

  logic        clk = 1'b0;
  logic        CPU_rst;
  logic        r0_initiate_op, r0_read_write, r1_initiate_op, r1_read_write;
  logic [15:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [15:0] r0_rdata, r1_rdata;
  logic        r0_op_complete, r1_op_complete;
  logic [15:0] MAB, MDB_out, MDB_in;
  logic        read_write, initiate_op, MDB_oe, op_complete, bus_error;
  logic [1:0]  grant;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .CPU_rst(CPU_rst),
    .r0_initiate_op(r0_initiate_op), .r0_read_write(r0_read_write),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rdata(r0_rdata), .r0_op_complete(r0_op_complete),
    .r1_initiate_op(r1_initiate_op), .r1_read_write(r1_read_write),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rdata(r1_rdata), .r1_op_complete(r1_op_complete),
    .MAB(MAB), .read_write(read_write), .initiate_op(initiate_op),
    .MDB_out(MDB_out), .MDB_oe(MDB_oe), .MDB_in(MDB_in),
    .op_complete(op_complete), .grant(grant), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int c0 = 0, c1 = 0, coe = 0, cbe = 0;

  always @(posedge clk) begin
    if (r0_op_complete) c0 <= c0 + 1;
    if (r1_op_complete) c1 <= c1 + 1;
    if (MDB_oe)         coe <= coe + 1;
    if (bus_error)      cbe <= cbe + 1;
  end

  typedef struct {
    logic        n;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdata;
    int          delay;
    logic [1:0]  grant;
    logic [15:0] exp_r0;
    logic [15:0] exp_r1;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic n, input logic req, input logic rw,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (n) begin
      r1_initiate_op = req; r1_read_write = rw; r1_addr = addr; r1_wdata = wdata;
    end else begin
      r0_initiate_op = req; r0_read_write = rw; r0_addr = addr; r0_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    CPU_rst = 1'b1;
    tick();
    tick();
    CPU_rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int s0, s1, soe;
    s0 = c0; s1 = c1; soe = coe;
    drive(v.n, 1'b1, v.rw, v.addr, v.wdata);
    tick();
    chk("issue_latency", {31'd0, initiate_op}, 32'd1);
    chk("mab", {16'd0, MAB}, {16'd0, v.addr});
    chk("read_write", {31'd0, read_write}, {31'd0, v.rw});
    chk("mdb_oe", {31'd0, MDB_oe}, {31'd0, !v.rw});
    if (!v.rw) chk("mdb_out", {16'd0, MDB_out}, {16'd0, v.wdata});
    chk("grant", {30'd0, grant}, {30'd0, v.grant});
    tick();
    repeat (v.delay) begin
      chk("wait_hold", {14'd0, initiate_op, MAB, MDB_oe, r0_op_complete | r1_op_complete},
          {14'd0, 1'b1, v.addr, !v.rw, 1'b0});
      tick();
    end
    op_complete = 1'b1;
    MDB_in      = v.mdata;
    tick();
    chk("done_pulse", {30'd0, r1_op_complete, r0_op_complete}, {30'd0, v.grant});
    chk("bus_released", {30'd0, initiate_op, MDB_oe}, 32'd0);
    chk("r0_rdata", {16'd0, r0_rdata}, {16'd0, v.exp_r0});
    chk("r1_rdata", {16'd0, r1_rdata}, {16'd0, v.exp_r1});
    chk("grant_in_release", {30'd0, grant}, {30'd0, v.grant});
    op_complete = 1'b0;
    drive(v.n, 1'b0, v.rw, v.addr, v.wdata);
    tick();
    chk("back_to_idle", {29'd0, grant, r0_op_complete | r1_op_complete}, 32'd0);
    chk("pulse_count", (c0 - s0) + 2 * (c1 - s1), v.n ? 32'd2 : 32'd1);
    chk("oe_cycles", coe - soe, v.rw ? 32'd0 : 32'(v.delay + 2));
  endtask

  task automatic wait_issue(input string name);
    int k = 0;
    while (!initiate_op && k < 8) begin
      tick();
      k++;
    end
    chk(name, {31'd0, initiate_op}, 32'd1);
  endtask

  initial begin
    int s0;
    logic [1:0] exp_g[4];
    vecs[0] = '{1'b0, 1'b1, 16'h0040, 16'h0000, 16'h4049, 2, 2'b01, 16'h4049, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0100, 16'hBEEF, 16'h1234, 1, 2'b10, 16'h4049, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 16'h0200, 16'h0000, 16'hA5A5, 0, 2'b10, 16'h4049, 16'hA5A5};
    vecs[3] = '{1'b0, 1'b0, 16'h0300, 16'hCAFE, 16'h5555, 3, 2'b01, 16'h4049, 16'hA5A5};
    vecs[4] = '{1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'h0001, 0, 2'b01, 16'h0001, 16'hA5A5};
    vecs[5] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h7E7E, 4, 2'b10, 16'h0001, 16'h7E7E};
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;

    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    op_complete = 1'b0;
    MDB_in      = 16'h0000;
    CPU_rst     = 1'b1;
    tick();
    tick();
    chk("reset_mab_mdb", {MAB, MDB_out}, 32'd0);
    chk("reset_rdata", {r0_rdata, r1_rdata}, 32'd0);
    chk("reset_ctrl", {25'd0, read_write, initiate_op, MDB_oe, r0_op_complete,
                       r1_op_complete, bus_error, grant != 2'b00}, 32'd0);
    CPU_rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Continuous contention from a fresh reset: r0 first, then alternating
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0);
    drive(1'b1, 1'b1, 1'b1, 16'h0020, 16'h0);
    for (int k = 0; k < 4; k++) begin
      wait_issue("contend_issue");
      chk("contend_grant", {30'd0, grant}, {30'd0, exp_g[k]});
      tick();
      op_complete = 1'b1;
      MDB_in      = 16'(k);
      tick();
      chk("contend_pulse", {30'd0, r1_op_complete, r0_op_complete}, {30'd0, exp_g[k]});
      op_complete = 1'b0;
      if (k == 3) begin
        r0_initiate_op = 1'b0;
        r1_initiate_op = 1'b0;
      end
      tick();
      chk("contend_gap", {31'd0, initiate_op}, 32'd0);
    end
    tick();
    chk("contend_quiet", {30'd0, grant}, 32'd0);

    // op_complete held for two cycles, requester keeps requesting
    s0 = c0;
    drive(1'b0, 1'b1, 1'b1, 16'h0555, 16'h0);
    tick();
    tick();
    op_complete = 1'b1;
    MDB_in      = 16'h1111;
    tick();
    chk("long_done_pulse", {31'd0, r0_op_complete}, 32'd1);
    tick();
    chk("long_no_second_pulse", {30'd0, r0_op_complete, initiate_op}, 32'd0);
    chk("long_grant_held", {30'd0, grant}, 32'd1);
    op_complete = 1'b0;
    tick();
    chk("long_idle", {31'd0, initiate_op}, 32'd0);
    tick();
    chk("long_reissue", {31'd0, initiate_op}, 32'd1);
    chk("long_single_pulse", c0 - s0, 32'd1);

    // Reset in WAIT abandons the transfer immediately
    tick();
    CPU_rst = 1'b1;
    #1;
    chk("async_rst", {29'd0, initiate_op, grant}, 32'd0);
    r0_initiate_op = 1'b0;
    tick();
    tick();
    CPU_rst = 1'b0;
    tick();
    chk("rst_no_pulse", c0 - s0, 32'd1);
    chk("rst_rdata", {16'd0, r0_rdata}, 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    drive(1'b0, 1'b1, 1'b1, 16'h0777, 16'h0);
    tick();
    chk("tmo_issue", {31'd0, initiate_op}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tmo_waiting", {29'd0, initiate_op, r0_op_complete, bus_error}, 32'd4);
    end
    tick();
    chk("tmo_abort", {29'd0, initiate_op, r0_op_complete, bus_error}, 32'd3);
    chk("tmo_rdata", {16'd0, r0_rdata}, 32'h0000FFFF);
    r0_initiate_op = 1'b0;
    tick();
    chk("tmo_berr_pulse", {31'd0, bus_error}, 32'd0);
`endif
    tick();
    chk("bus_error_count", cbe, EXP_BE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
